// File: rtl/led_sched_pkg.sv
// Shared encodings and arbitration helper for the port LED source scheduler.
package led_sched_pkg;

    localparam logic [1:0] GNT_VER  = 2'd0;
    localparam logic [1:0] GNT_ERR  = 2'd1;
    localparam logic [1:0] GNT_DL   = 2'd2;
    localparam logic [1:0] GNT_LINK = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } sched_state_t;

    // Fixed priority ver > err > dl; link is the fallback and needs no request.
    function automatic logic [1:0] pick_winner(input logic req_ver,
                                               input logic req_err,
                                               input logic req_dl);
        if (req_ver)      return GNT_VER;
        else if (req_err) return GNT_ERR;
        else if (req_dl)  return GNT_DL;
        else              return GNT_LINK;
    endfunction

endpackage

// File: rtl/ms_timebase.sv
// Millisecond prescaler: free-running 0..CLK_DIV-1 count with a 1-cycle tick at the top.
module ms_timebase #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_ms
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick_ms = en & ~rst & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_src_sched.sv
// Port LED source scheduler: priority grant with minimum hold time, blink and activity stretch.
//
//   state | meaning
//   IDLE  | no request, link/activity shown (grant=3)
//   HOLD  | source freshly granted, only ver preemption or request drop can move it
//   OPEN  | hold time served, winner re-evaluated every cycle
module led_src_sched
    import led_sched_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int HOLD_MS  = 200,
    parameter int BLINK_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_done,
    input  logic       req_ver,
    input  logic       ver_led,
    input  logic       req_err,
    input  logic       req_dl,
    input  logic       link_on,
    input  logic       rx_act,
    output logic       led_on,
    output logic [1:0] grant,
    output logic       tick_ms
);

    if (CLK_DIV < 1 || HOLD_MS < 1 || BLINK_MS < 1) begin : g_param_check
        $error("led_src_sched: CLK_DIV, HOLD_MS and BLINK_MS must all be nonzero");
    end

    localparam int HW = (HOLD_MS > 0)  ? $clog2(HOLD_MS + 1)  : 1;
    localparam int BW = (BLINK_MS > 0) ? $clog2(BLINK_MS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_MS);
    localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_MS);

    sched_state_t   state, state_nxt;
    logic [1:0]     grant_nxt;
    logic [1:0]     winner;
    logic [HW-1:0]  hold_cnt, hold_nxt;
    logic [BW-1:0]  blink_cnt, act_cnt;
    logic           phase;
    logic           req_ver_d;
    logic           sync_rst;
    logic           any_req;
    logic           gnt_req;
    logic           ver_rise;

    assign sync_rst = rst | ~c_done;
    assign winner   = pick_winner(req_ver, req_err, req_dl);
    assign any_req  = req_ver | req_err | req_dl;
    assign ver_rise = req_ver & ~req_ver_d;

    ms_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .en      (c_done),
        .tick_ms (tick_ms)
    );

    always_comb begin
        gnt_req = 1'b1;
        case (grant)
            GNT_VER: gnt_req = req_ver;
            GNT_ERR: gnt_req = req_err;
            GNT_DL:  gnt_req = req_dl;
            default: gnt_req = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                grant_nxt = GNT_LINK;
                if (any_req) begin
                    state_nxt = HOLD;
                    grant_nxt = winner;
                    hold_nxt  = HOLD_LD;
                end
            end
            HOLD: begin
                // Preempt outranks re-arbitration, which outranks the hold count.
                if (ver_rise && grant != GNT_VER) begin
                    grant_nxt = GNT_VER;
                    hold_nxt  = HOLD_LD;
                end else if (!gnt_req) begin
                    if (any_req) begin
                        grant_nxt = winner;
                        hold_nxt  = HOLD_LD;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = GNT_LINK;
                    end
                end else if (hold_cnt == '0) begin
                    state_nxt = OPEN;
                end else if (tick_ms) begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            OPEN: begin
                if (!any_req) begin
                    state_nxt = IDLE;
                    grant_nxt = GNT_LINK;
                end else if (winner != grant) begin
                    state_nxt = HOLD;
                    grant_nxt = winner;
                    hold_nxt  = HOLD_LD;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = GNT_LINK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state     <= IDLE;
            grant     <= GNT_LINK;
            hold_cnt  <= '0;
            req_ver_d <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            hold_cnt  <= hold_nxt;
            req_ver_d <= req_ver;
        end
    end

    // A decrement that would reach zero reloads instead, so phase toggles every BLINK_MS ticks.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            phase     <= 1'b1;
            blink_cnt <= '0;
        end else if (grant_nxt != grant) begin
            phase     <= 1'b1;
            blink_cnt <= BLINK_LD;
        end else if (tick_ms) begin
            if (blink_cnt <= BW'(1)) begin
                blink_cnt <= BLINK_LD;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            act_cnt <= '0;
        end else if (rx_act) begin
            act_cnt <= BLINK_LD;
        end else if (tick_ms && act_cnt != '0) begin
            act_cnt <= act_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            led_on <= 1'b0;
        end else begin
            case (grant)
                GNT_VER: led_on <= ver_led;
                GNT_ERR: led_on <= phase;
                GNT_DL:  led_on <= 1'b1;
                default: led_on <= link_on & (act_cnt == '0);
            endcase
        end
    end

endmodule

// File: tb/tb_led_src_sched.sv
// Directed bench for led_src_sched with CLK_DIV=4, HOLD_MS=3, BLINK_MS=2; cycle numbers are edges since release.
module tb_led_src_sched;

    logic       clk = 1'b0;
    logic       rst, c_done, req_ver, ver_led, req_err, req_dl, link_on, rx_act;
    logic       led_on, tick_ms;
    logic [1:0] grant;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_src_sched #(.CLK_DIV(4), .HOLD_MS(3), .BLINK_MS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .c_done  (c_done),
        .req_ver (req_ver),
        .ver_led (ver_led),
        .req_err (req_err),
        .req_dl  (req_dl),
        .link_on (link_on),
        .rx_act  (rx_act),
        .led_on  (led_on),
        .grant   (grant),
        .tick_ms (tick_ms)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; c_done = 1'b0; req_ver = 1'b0; ver_led = 1'b0;
        req_err = 1'b0; req_dl = 1'b0; link_on = 1'b0; rx_act = 1'b0;
        repeat (3) step();
        chk("rst_grant", grant, 3);
        chk("rst_led", led_on, 0);
        chk("rst_tick", tick_ms, 0);

        // 1: link default, tick every 4th cycle
        rst = 1'b0; c_done = 1'b1; link_on = 1'b1; cyc = 0;
        go(1);
        chk("t1_grant", grant, 3);
        chk("t1_led", led_on, 1);
        for (int k = 2; k <= 9; k++) begin
            go(k);
            chk("t1_tick", tick_ms, ((k % 4) == 3) ? 1 : 0);
        end

        // 2: dl held for 3 ticks, err takes over after the hold, then blinks
        req_dl = 1'b1;
        go(10); chk("t2_dl_grant", grant, 2);
        go(16); chk("t2_dl_hold", grant, 2);
        req_err = 1'b1;
        go(21); chk("t2_dl_still", grant, 2);
        go(22); chk("t2_err_grant", grant, 1);
        go(23); chk("t2_blink_a", led_on, 1);
        go(28); chk("t2_blink_b", led_on, 1);
        go(29); chk("t2_blink_c", led_on, 0);
        go(36); chk("t2_blink_d", led_on, 0);
        go(37); chk("t2_blink_e", led_on, 1);
        chk("t2_err_keep", grant, 1);

        // 4: err drops in OPEN -> dl in HOLD; dl drops -> IDLE
        req_err = 1'b0;
        go(38); chk("t4_dl_hold", grant, 2);
        req_dl = 1'b0;
        go(39); chk("t4_idle", grant, 3);

        // 3: ver preempts err in HOLD, LED follows ver_led
        req_err = 1'b1;
        go(40); chk("t3_err_grant", grant, 1);
        req_ver = 1'b1; ver_led = 1'b1;
        go(41); chk("t3_preempt", grant, 0);
        ver_led = 1'b0;
        go(42); chk("t3_ver_led0", led_on, 0);
        ver_led = 1'b1;
        go(43); chk("t3_ver_led1", led_on, 1);

        // 6: ver drops -> err re-granted in HOLD, then reset mid-HOLD
        req_ver = 1'b0;
        go(44); chk("t6_rearb", grant, 1);
        rst = 1'b1;
        go(45);
        chk("t6_rst_grant", grant, 3);
        chk("t6_rst_led", led_on, 0);
        chk("t6_rst_tick", tick_ms, 0);
        rst = 1'b0; cyc = 0;
        go(1);
        chk("t6_resume_grant", grant, 1);
        chk("t6_resume_tick", tick_ms, 0);
        go(2); chk("t6_resume_led", led_on, 1);
        go(3); chk("t6_resume_tick3", tick_ms, 1);
        go(8); chk("t6_blink_a", led_on, 1);
        go(9); chk("t6_blink_b", led_on, 0);

        // 5: activity stretch with retrigger
        req_err = 1'b0;
        go(10); chk("t5_idle", grant, 3);
        go(11); chk("t5_link", led_on, 1);
        rx_act = 1'b1;
        go(12); rx_act = 1'b0;
        chk("t5_lag", led_on, 1);
        go(13); chk("t5_act_a", led_on, 0);
        go(16); chk("t5_act_b", led_on, 0);
        rx_act = 1'b1;
        go(17); rx_act = 1'b0;
        go(20); chk("t5_act_c", led_on, 0);
        go(24); chk("t5_act_d", led_on, 0);
        go(25); chk("t5_act_end", led_on, 1);

        // c_done low holds reset state
        c_done = 1'b0;
        go(26);
        chk("cd_led", led_on, 0);
        chk("cd_grant", grant, 3);
        go(27); chk("cd_tick", tick_ms, 0);
        go(30); chk("cd_tick_b", tick_ms, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
